// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, data width, result record.
// Also provides the single combinational ALU evaluation used by the datapath.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] out;
    logic             zero;
    logic             carry;
  } alu_res_t;

  // Carry only means something for add/sub; the 9th bit is masked for every other opcode.
  function automatic alu_res_t alu_eval(input logic [2:0]       op,
                                        input logic [ALU_W-1:0] a,
                                        input logic [ALU_W-1:0] b);
    logic [ALU_W:0] wide;
    logic           is_arith;
    alu_res_t       res;
    is_arith = 1'b0;
    case (op)
      ALU_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        is_arith = 1'b1;
      end
      ALU_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        is_arith = 1'b1;
      end
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_NOT: wide = {1'b0, ~a};
      ALU_SHL: wide = {1'b0, a << 1};
      default: wide = {1'b0, a >> 1};
    endcase
    res.out   = wide[ALU_W-1:0];
    res.zero  = (wide[ALU_W-1:0] == '0);
    res.carry = is_arith & wide[ALU_W];
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping to index 0.
// Latency: combinational, zero cycles.
// Backpressure: grant is forced to zero while enable is low; idx/any still reflect req.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic           hit_hi;
  logic           hit_lo;
  logic [IDW-1:0] idx_hi;
  logic [IDW-1:0] idx_lo;

  // Scan high to low so the last hit written is the lowest index in each range.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_lo = 1'b1;
        idx_lo = IDW'(i);
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    any   = hit_lo;
    idx   = hit_hi ? idx_hi : idx_lo;
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = enable && hit_lo && (idx == IDW'(i));
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU between NREQ requesters, round-robin, one op per cycle.
// Latency: result registered one cycle after the request handshake.
// Backpressure: a held response (rsp_valid && !rsp_ready) blocks all req_ready and freezes rsp_*.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_out,
  output logic                  rsp_zero,
  output logic                  rsp_carry
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  alu_res_t         rsp_res_q, rsp_res_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             can_issue;
  logic             issue;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  logic [2:0]       sel_op;
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;
  alu_res_t         alu_res;

  // rst_n in the enable keeps req_ready low for the whole reset window.
  assign can_issue = rst_n && (!rsp_valid_q || rsp_ready);
  assign issue     = can_issue && win_any;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (can_issue),
    .grant  (grant),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[ALU_W*i +: ALU_W];
        sel_b  = req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  assign alu_res = alu_eval(sel_op, sel_a, sel_b);

  // An issue in the same cycle as a drain simply overwrites the old result.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    ptr_d       = ptr_q;
    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_idx;
      rsp_res_d   = alu_res;
      ptr_d       = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_res_q.out;
  assign rsp_zero  = rsp_res_q.zero;
  assign rsp_carry = rsp_res_q.carry;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !rsp_ready) |=> (rsp_valid_q && $stable(rsp_res_q) && $stable(rsp_id_q)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors with hand-computed results plus a random sweep.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_out;
  logic              rsp_zero;
  logic              rsp_carry;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         hand;
    logic [7:0] eout;
    logic       ezero;
    logic       ecarry;
  } stim_t;

  typedef struct {
    int         id;
    logic [7:0] out;
    logic       zero;
    logic       carry;
  } exp_t;

  stim_t sq [NREQ][$];
  stim_t cur [NREQ];
  bit    vld [NREQ];
  exp_t  exp_q [$];
  int    glog [$];
  int    sent [NREQ];
  int    rcvd [NREQ];
  int    total = 0;
  int    bad   = 0;
  bit    m_valid;
  int    m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t gold(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   r;
    ia      = int'(a);
    ib      = int'(b);
    e.carry = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; e.carry = (r > 255); end
      3'd1: begin r = ia - ib; e.carry = (ia < ib); if (r < 0) r += 256; end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ia;
      3'd6: r = ia * 2;
      default: r = ia / 2;
    endcase
    e.out  = 8'(r % 256);
    e.zero = (e.out == 8'h00);
    e.id   = id;
    return e;
  endfunction

  task automatic put(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eo, input logic ez, input logic ec);
    stim_t s;
    s.op = op; s.a = a; s.b = b; s.hand = 1'b1; s.eout = eo; s.ezero = ez; s.ecarry = ec;
    sq[r].push_back(s);
  endtask

  task automatic put_rand(input int r);
    stim_t s;
    s.op = 3'($urandom_range(7)); s.a = 8'($urandom); s.b = 8'($urandom);
    s.hand = 1'b0; s.eout = '0; s.ezero = 1'b0; s.ecarry = 1'b0;
    sq[r].push_back(s);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = vld[i];
      req_op[3*i +: 3]  = cur[i].op;
      req_a[8*i +: 8]   = cur[i].a;
      req_b[8*i +: 8]   = cur[i].b;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < NREQ; i++) begin
      if (!vld[i] && sq[i].size() > 0) begin
        cur[i] = sq[i].pop_front();
        vld[i] = 1'b1;
      end
    end
    drive();
  endtask

  function automatic bit busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (vld[i] || sq[i].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  // One clock: check grants against the round-robin model at negedge, log the handshake, advance.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int              w;
    bit              can;
    exp_t            e;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, m_valid);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (w < 0 && vld[c]) w = c;
    end
    can     = !m_valid || rsp_ready;
    exp_rdy = '0;
    if (can && w >= 0) exp_rdy = NREQ'(1) << w;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (can && w >= 0) begin
      if (cur[w].hand) begin
        e.id = w; e.out = cur[w].eout; e.zero = cur[w].ezero; e.carry = cur[w].ecarry;
      end else begin
        e = gold(w, cur[w].op, cur[w].a, cur[w].b);
      end
      exp_q.push_back(e);
      glog.push_back(w);
      sent[w]++;
      m_ptr   = (w + 1) % NREQ;
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (can && w >= 0) vld[w] = 1'b0;
    load_all();
  endtask

  task automatic run_idle(input bit rnd, input int budget);
    int cyc;
    cyc = 0;
    while (busy() && cyc < budget) begin
      rsp_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      step();
      cyc++;
    end
    rsp_ready = 1'b1;
    chk("idle_timeout", 32'(busy()), 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_id"},    32'(rsp_id), 0);
    chk({p, "_rsp_out"},   rsp_out, 0);
    chk({p, "_rsp_zero"},  rsp_zero, 0);
    chk({p, "_rsp_carry"}, rsp_carry, 0);
    chk({p, "_req_ready"}, 32'(req_ready), 0);
  endtask

  // Monitor: compares every presented response against the scoreboard head, pops on consume.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = exp_q[0];
          chk("rsp_id",    32'(rsp_id), 32'(e.id));
          chk("rsp_out",   rsp_out, e.out);
          chk("rsp_zero",  rsp_zero, e.zero);
          chk("rsp_carry", rsp_carry, e.carry);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rcvd[e.id]++;
          end
        end
      end
    end
  end

  initial begin
    int exp_ids [6] = '{0, 1, 0, 1, 0, 1};
    int base;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '1;
    req_b     = '1;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b0; sent[i] = 0; rcvd[i] = 0;
    end
    m_valid = 1'b0;
    m_ptr   = 0;
    #12;
    chk_reset("por");
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: both requesters busy, grants must alternate starting at 0.
    glog.delete();
    put(0, 3'd4, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0);
    put(1, 3'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    put(0, 3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    put(1, 3'd7, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0);
    put(0, 3'd5, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0);
    put(1, 3'd1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    load_all();
    run_idle(1'b0, 50);
    chk("fair_count", glog.size(), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk($sformatf("fair_id%0d", k), glog[k], exp_ids[k]);

    // Backpressure: stall three cycles after the first issue, then drain and issue together.
    glog.delete();
    put(0, 3'd1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    put(1, 3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    load_all();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    chk("bp_valid_kept", rsp_valid, 1);
    chk("bp_new_id", 32'(rsp_id), 1);
    run_idle(1'b0, 20);
    chk("bp_count", glog.size(), 2);

    // Single requester with carry/zero corner cases.
    put(0, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    put(0, 3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
    put(0, 3'd6, 8'h80, 8'h55, 8'h00, 1'b1, 1'b0);
    put(0, 3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0);
    load_all();
    run_idle(1'b0, 30);

    // Reset during a stalled response: result discarded, pointer back to 0.
    glog.delete();
    put(0, 3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    put(0, 3'd4, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0);
    load_all();
    rsp_ready = 1'b0;
    step();
    put(1, 3'd3, 8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0);
    load_all();
    step();
    step();
    rst_n = 1'b0;
    #3;
    chk_reset("mid");
    foreach (exp_q[k]) sent[exp_q[k].id]--;
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    base      = glog.size();
    run_idle(1'b0, 20);
    if (glog.size() > base) chk("rst_first_grant", glog[base], 0);
    else chk("rst_first_grant_missing", glog.size(), base + 1);

    // Random sweep with random consumer backpressure.
    for (int n = 0; n < 1000; n++) put_rand($urandom_range(NREQ - 1));
    load_all();
    run_idle(1'b1, 20000);
    for (int i = 0; i < NREQ; i++) chk($sformatf("count_r%0d", i), rcvd[i], sent[i]);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
